// File: rtl/qracc_sram_ctrl.sv
// qracc_sram_ctrl: slave-side sequencer for the sram_itf request/response
// protocol. Each accepted single-row read or write becomes a timed
// precharge -> wordline -> (sense) sequence on the SRAM analog control lines.
// Optional feature: define QRACC_SRAM_WRITE_VERIFY_EN to add a readback of
// every written row and a wr_err_o flag reporting a mismatch.
module qracc_sram_ctrl #(
  parameter int numRows   = 128,
  parameter int numCols   = 32,
  parameter int pchCycles = 2,
  parameter int wlCycles  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rq_wr_i,
  input  logic                       rq_valid_i,
  output logic                       rq_ready_o,
  output logic                       rd_valid_o,
  output logic [numCols-1:0]         rd_data_o,
  input  logic [numCols-1:0]         wr_data_i,
  input  logic [$clog2(numRows)-1:0] addr_i,
  output logic [numRows-1:0]         WL,
  output logic                       PCH,
  output logic [numCols-1:0]         WR_DATA,
  output logic                       WRITE,
  output logic [numCols-1:0]         CSEL,
  output logic                       SAEN,
  input  logic [numCols-1:0]         SA_OUT
`ifdef QRACC_SRAM_WRITE_VERIFY_EN
  ,
  output logic                       wr_err_o
`endif
);

  localparam int AW   = $clog2(numRows);
  localparam int CMAX = (pchCycles > wlCycles) ? pchCycles : wlCycles;
  // Counter only needs to reach CMAX-1 before the state is left.
  localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);
  localparam logic [CW-1:0] P_LAST = CW'(pchCycles - 1);
  localparam logic [CW-1:0] W_LAST = CW'(wlCycles - 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_PCH     = 4'd1;
  localparam logic [3:0] S_WL      = 4'd2;
  localparam logic [3:0] S_SENSE   = 4'd3;
  localparam logic [3:0] S_DONE    = 4'd4;
`ifdef QRACC_SRAM_WRITE_VERIFY_EN
  localparam logic [3:0] S_VPCH    = 4'd5;
  localparam logic [3:0] S_VWL     = 4'd6;
  localparam logic [3:0] S_VSENSE  = 4'd7;
  localparam logic [3:0] S_VDONE   = 4'd8;
`endif

  logic [3:0]         state, nxt;
  logic [CW-1:0]      cnt;
  logic [AW-1:0]      addr_q;
  logic               wr_q;
  logic [numCols-1:0] data_q;
  logic               wl_on;
  logic               sense_on;
  logic [numRows-1:0] row_one;

  // Next-state decode; requests are only looked at while idle.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (rq_valid_i) nxt = S_PCH;
      S_PCH:   if (cnt == P_LAST) nxt = S_WL;
      S_WL:    if (cnt == W_LAST) begin
`ifdef QRACC_SRAM_WRITE_VERIFY_EN
                 nxt = wr_q ? S_VPCH : S_SENSE;
`else
                 nxt = wr_q ? S_IDLE : S_SENSE;
`endif
               end
      S_SENSE: nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
`ifdef QRACC_SRAM_WRITE_VERIFY_EN
      S_VPCH:   if (cnt == P_LAST) nxt = S_VWL;
      S_VWL:    if (cnt == W_LAST) nxt = S_VSENSE;
      S_VSENSE: nxt = S_VDONE;
      S_VDONE:  nxt = S_IDLE;
`endif
      default: nxt = S_IDLE;
    endcase
  end

  // State register and phase counter, counter restarts on every state entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state) ? '0 : cnt + 1'b1;
    end
  end

  // Request fields are captured only on the acceptance edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      wr_q   <= 1'b0;
      data_q <= '0;
    end else if (state == S_IDLE && rq_valid_i) begin
      addr_q <= addr_i;
      wr_q   <= rq_wr_i;
      data_q <= wr_data_i;
    end
  end

  // Sense-amp result captured on the edge that ends SENSE; held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_o <= '0;
    else if (state == S_SENSE) rd_data_o <= SA_OUT;
  end

`ifdef QRACC_SRAM_WRITE_VERIFY_EN
  logic err_q;

  // Compare the readback against the written row at the end of VSENSE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else if (state == S_VSENSE) err_q <= (SA_OUT != data_q);
  end

  assign wr_err_o = (state == S_VDONE) && err_q;
  assign wl_on    = (state == S_WL) || (state == S_SENSE) ||
                    (state == S_VWL) || (state == S_VSENSE);
  assign sense_on = (state == S_SENSE) || (state == S_VSENSE);
  assign PCH      = (state == S_PCH) || (state == S_VPCH);
`else
  assign wl_on    = (state == S_WL) || (state == S_SENSE);
  assign sense_on = (state == S_SENSE);
  assign PCH      = (state == S_PCH);
`endif

  // All outputs decode from registered state/fields only, so reset drops the
  // analog lines asynchronously through the state register.
  assign row_one    = {{(numRows-1){1'b0}}, 1'b1};
  assign WL         = wl_on ? (row_one << addr_q) : '0;
  assign CSEL       = wl_on ? '1 : '0;
  assign WRITE      = (state == S_WL) && wr_q;
  assign WR_DATA    = WRITE ? data_q : '0;
  assign SAEN       = sense_on;
  assign rq_ready_o = (state == S_IDLE);
  assign rd_valid_o = (state == S_DONE);

endmodule
